// File: rtl/esfa_command_sequencer.sv
// esfa_command_sequencer: host command sequencer driving the 8-cell ESFA
// associative memory array (write / metadata / query) with a registered
// array-side interface and a valid/ready response channel for queries.
// Optional build macro: ESFA_CMD_SKID_EN adds a 1-entry command holding
// register so one command can be accepted while the sequencer is busy.
module esfa_command_sequencer #(
  parameter int unsigned HOLD_CYCLES = 1,
  parameter int unsigned QUERY_LAT   = 1,
  parameter logic [7:0]  IDLE_INDEX  = 8'hFF
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       cmd_valid_i,
  output logic       cmd_ready_o,
  input  logic [1:0] cmd_op_i,
  input  logic [7:0] cmd_index_i,
  input  logic [7:0] cmd_value_i,
  output logic [7:0] new_index_o,
  output logic [7:0] new_value_o,
  output logic [7:0] metadata_o,
  output logic       isMetadata_o,
  output logic [7:0] selector_o,
  input  logic       resultBool_i,
  input  logic [7:0] resultValue_i,
  output logic       rsp_valid_o,
  input  logic       rsp_ready_i,
  output logic       rsp_bool_o,
  output logic [7:0] rsp_value_o,
  output logic       busy_o
);

  typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_WAIT, S_RESP} state_t;
  typedef enum logic [1:0] {OP_NOP = 2'd0, OP_WRITE = 2'd1, OP_META = 2'd2, OP_QUERY = 2'd3} op_t;

  // Counters are loaded with N-1 so the state lasts exactly N cycles.
  localparam int unsigned HOLD_EFF = (HOLD_CYCLES == 0) ? 1 : ((HOLD_CYCLES > 15) ? 15 : HOLD_CYCLES);
  localparam int unsigned QLAT_EFF = (QUERY_LAT == 0) ? 1 : ((QUERY_LAT > 15) ? 15 : QUERY_LAT);
  localparam logic [3:0]  HOLD_LD  = 4'(HOLD_EFF - 1);
  localparam logic [3:0]  QLAT_LD  = 4'(QLAT_EFF - 1);

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  op_t        op_q, op_d;
  logic [7:0] new_index_q, new_index_d;
  logic [7:0] new_value_q, new_value_d;
  logic [7:0] metadata_q, metadata_d;
  logic       is_meta_q, is_meta_d;
  logic [7:0] selector_q, selector_d;
  logic       rsp_valid_q, rsp_valid_d;
  logic       rsp_bool_q, rsp_bool_d;
  logic [7:0] rsp_value_q, rsp_value_d;

  logic       accept;
  logic       disp_go;
  op_t        disp_op;
  logic [7:0] disp_index;
  logic [7:0] disp_value;

  assign accept = cmd_valid_i && cmd_ready_o;

`ifdef ESFA_CMD_SKID_EN
  logic       skid_full_q, skid_full_d;
  op_t        skid_op_q;
  logic [7:0] skid_index_q;
  logic [7:0] skid_value_q;

  assign cmd_ready_o = !skid_full_q;

  // Dispatch source: a held command has priority; while it is held
  // cmd_ready is low, so the two sources never compete.
  always_comb begin
    disp_go    = 1'b0;
    disp_op    = OP_NOP;
    disp_index = '0;
    disp_value = '0;
    if (state_q == S_IDLE) begin
      if (skid_full_q) begin
        disp_go    = 1'b1;
        disp_op    = skid_op_q;
        disp_index = skid_index_q;
        disp_value = skid_value_q;
      end else if (accept) begin
        disp_go    = 1'b1;
        disp_op    = op_t'(cmd_op_i);
        disp_index = cmd_index_i;
        disp_value = cmd_value_i;
      end
    end
  end

  // Holding register fills on an accept while busy, empties on dispatch.
  always_comb begin
    skid_full_d = skid_full_q;
    if (state_q == S_IDLE && skid_full_q) skid_full_d = 1'b0;
    if (accept && state_q != S_IDLE)      skid_full_d = 1'b1;
  end

  // Holding register storage.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      skid_full_q  <= 1'b0;
      skid_op_q    <= OP_NOP;
      skid_index_q <= '0;
      skid_value_q <= '0;
    end else begin
      skid_full_q <= skid_full_d;
      if (accept && state_q != S_IDLE) begin
        skid_op_q    <= op_t'(cmd_op_i);
        skid_index_q <= cmd_index_i;
        skid_value_q <= cmd_value_i;
      end
    end
  end
`else
  assign cmd_ready_o = (state_q == S_IDLE);

  // Without the holding register only an idle accept dispatches.
  always_comb begin
    disp_go    = accept;
    disp_op    = op_t'(cmd_op_i);
    disp_index = cmd_index_i;
    disp_value = cmd_value_i;
  end
`endif

  // State, counter and registered outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      op_q        <= OP_NOP;
      new_index_q <= IDLE_INDEX;
      new_value_q <= '0;
      metadata_q  <= '0;
      is_meta_q   <= 1'b0;
      selector_q  <= '0;
      rsp_valid_q <= 1'b0;
      rsp_bool_q  <= 1'b0;
      rsp_value_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      new_index_q <= new_index_d;
      new_value_q <= new_value_d;
      metadata_q  <= metadata_d;
      is_meta_q   <= is_meta_d;
      selector_q  <= selector_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_bool_q  <= rsp_bool_d;
      rsp_value_q <= rsp_value_d;
    end
  end

  // Next-state and counter sequencing.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    case (state_q)
      S_IDLE: begin
        if (disp_go && disp_op != OP_NOP) begin
          state_d = S_DRIVE;
          op_d    = disp_op;
          cnt_d   = (disp_op == OP_QUERY) ? '0 : HOLD_LD;
        end
      end
      S_DRIVE: begin
        if (op_q == OP_QUERY) begin
          state_d = S_WAIT;
          cnt_d   = QLAT_LD;
        end else if (cnt_q == '0) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) state_d = S_RESP;
        else             cnt_d   = cnt_q - 4'd1;
      end
      S_RESP: begin
        if (rsp_ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Next values of the registered array-side and response outputs.
  always_comb begin
    new_index_d = new_index_q;
    new_value_d = new_value_q;
    metadata_d  = metadata_q;
    is_meta_d   = is_meta_q;
    selector_d  = selector_q;
    rsp_valid_d = rsp_valid_q;
    rsp_bool_d  = rsp_bool_q;
    rsp_value_d = rsp_value_q;
    case (state_q)
      S_IDLE: begin
        if (disp_go) begin
          case (disp_op)
            OP_WRITE: begin
              new_index_d = disp_index;
              new_value_d = disp_value;
              is_meta_d   = 1'b0;
            end
            OP_META: begin
              metadata_d = disp_value;
              is_meta_d  = 1'b1;
            end
            OP_QUERY: selector_d = disp_value;
            default: ;
          endcase
        end
      end
      S_DRIVE: begin
        if (op_q != OP_QUERY && cnt_q == '0) begin
          new_index_d = IDLE_INDEX;
          new_value_d = '0;
          metadata_d  = '0;
          is_meta_d   = 1'b0;
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          rsp_bool_d  = resultBool_i;
          rsp_value_d = resultValue_i;
          rsp_valid_d = 1'b1;
          selector_d  = '0;
        end
      end
      S_RESP: begin
        if (rsp_ready_i) begin
          rsp_valid_d = 1'b0;
          rsp_bool_d  = 1'b0;
          rsp_value_d = '0;
        end
      end
      default: ;
    endcase
  end

  assign new_index_o  = new_index_q;
  assign new_value_o  = new_value_q;
  assign metadata_o   = metadata_q;
  assign isMetadata_o = is_meta_q;
  assign selector_o   = selector_q;
  assign rsp_valid_o  = rsp_valid_q;
  assign rsp_bool_o   = rsp_bool_q;
  assign rsp_value_o  = rsp_value_q;
  assign busy_o       = (state_q != S_IDLE);

endmodule

// File: tb/tb_esfa_command_sequencer.sv
// Directed self-checking bench for esfa_command_sequencer
// (HOLD_CYCLES=3, QUERY_LAT=2). A tiny array model answers selector 8'h04
// with resultBool=1, resultValue=8'h77 and everything else with 0/8'h00.
module tb_esfa_command_sequencer;

  logic       clk;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [7:0] cmd_index;
  logic [7:0] cmd_value;
  logic [7:0] new_index;
  logic [7:0] new_value;
  logic [7:0] metadata;
  logic       is_meta;
  logic [7:0] selector;
  logic       result_bool;
  logic [7:0] result_value;
  logic       rsp_valid;
  logic       rsp_ready;
  logic       rsp_bool;
  logic [7:0] rsp_value;
  logic       busy;

  int passed = 0;
  int total  = 0;

  esfa_command_sequencer #(
    .HOLD_CYCLES(3),
    .QUERY_LAT  (2),
    .IDLE_INDEX (8'hFF)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .cmd_valid_i  (cmd_valid),
    .cmd_ready_o  (cmd_ready),
    .cmd_op_i     (cmd_op),
    .cmd_index_i  (cmd_index),
    .cmd_value_i  (cmd_value),
    .new_index_o  (new_index),
    .new_value_o  (new_value),
    .metadata_o   (metadata),
    .isMetadata_o (is_meta),
    .selector_o   (selector),
    .resultBool_i (result_bool),
    .resultValue_i(result_value),
    .rsp_valid_o  (rsp_valid),
    .rsp_ready_i  (rsp_ready),
    .rsp_bool_o   (rsp_bool),
    .rsp_value_o  (rsp_value),
    .busy_o       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign result_bool  = (selector == 8'h04);
  assign result_value = (selector == 8'h04) ? 8'h77 : 8'h00;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one command and return 1 ns after the edge that accepted it.
  task automatic issue(input logic [1:0] op, input logic [7:0] idx, input logic [7:0] val);
    int n;
    n = 0;
    cmd_op = op; cmd_index = idx; cmd_value = val; cmd_valid = 1'b1;
    while (!cmd_ready && n < 100) begin step(); n++; end
    if (n >= 100) begin total++; $display("FAIL issue_timeout: cmd_ready=0 for 100 cycles, expected 1"); end
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_index = '0; cmd_value = '0; rsp_ready = 1'b0;
    #23;
    total++; if (new_index !== 8'hFF) $display("FAIL rst_new_index: got %h exp ff", new_index); else passed++;
    total++; if (new_value !== 8'h00) $display("FAIL rst_new_value: got %h exp 00", new_value); else passed++;
    total++; if (metadata !== 8'h00) $display("FAIL rst_metadata: got %h exp 00", metadata); else passed++;
    total++; if (is_meta !== 1'b0) $display("FAIL rst_isMetadata: got %b exp 0", is_meta); else passed++;
    total++; if (selector !== 8'h00) $display("FAIL rst_selector: got %h exp 00", selector); else passed++;
    total++; if (rsp_valid !== 1'b0 || rsp_bool !== 1'b0 || rsp_value !== 8'h00)
      $display("FAIL rst_rsp: got v=%b b=%b val=%h exp 0/0/00", rsp_valid, rsp_bool, rsp_value); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b exp 0", busy); else passed++;
    @(negedge clk); rst_n = 1'b1;
    step();
    total++; if (cmd_ready !== 1'b1) $display("FAIL rst_cmd_ready: got %b exp 1", cmd_ready); else passed++;
    // Reset in the middle of a WRITE hold.
    issue(2'd1, 8'h03, 8'h5A);
    total++; if (new_index !== 8'h03 || new_value !== 8'h5A)
      $display("FAIL midwr_fields: got %h/%h exp 03/5a", new_index, new_value); else passed++;
    #2 rst_n = 1'b0;
    #1;
    total++; if (new_index !== 8'hFF || new_value !== 8'h00)
      $display("FAIL midrst_fields: got %h/%h exp ff/00", new_index, new_value); else passed++;
    total++; if (busy !== 1'b0 || rsp_valid !== 1'b0)
      $display("FAIL midrst_busy_rsp: got busy=%b rsp_valid=%b exp 0/0", busy, rsp_valid); else passed++;
    @(negedge clk); rst_n = 1'b1;
    step();
    total++; if (cmd_ready !== 1'b1 || new_index !== 8'hFF)
      $display("FAIL postrst_idle: got ready=%b idx=%h exp 1/ff", cmd_ready, new_index); else passed++;
  endtask

  task automatic test_write();
    issue(2'd1, 8'h02, 8'hA5);
    for (int i = 0; i < 3; i++) begin
      total++; if (new_index !== 8'h02 || new_value !== 8'hA5 || is_meta !== 1'b0)
        $display("FAIL wr_hold[%0d]: got %h/%h/%b exp 02/a5/0", i, new_index, new_value, is_meta); else passed++;
      total++; if (busy !== 1'b1 || rsp_valid !== 1'b0 || cmd_ready !== 1'b0)
        $display("FAIL wr_ctrl[%0d]: got busy=%b rsp_valid=%b ready=%b exp 1/0/0", i, busy, rsp_valid, cmd_ready); else passed++;
      step();
    end
    total++; if (new_index !== 8'hFF || new_value !== 8'h00)
      $display("FAIL wr_release: got %h/%h exp ff/00", new_index, new_value); else passed++;
    total++; if (busy !== 1'b0 || cmd_ready !== 1'b1 || rsp_valid !== 1'b0)
      $display("FAIL wr_idle: got busy=%b ready=%b rsp_valid=%b exp 0/1/0", busy, cmd_ready, rsp_valid); else passed++;
  endtask

  task automatic test_meta_query();
    int n;
    rsp_ready = 1'b1;
    issue(2'd2, 8'h00, 8'h11);
    for (int i = 0; i < 3; i++) begin
      total++; if (is_meta !== 1'b1 || metadata !== 8'h11 || new_index !== 8'hFF)
        $display("FAIL meta_hold[%0d]: got isMeta=%b md=%h idx=%h exp 1/11/ff", i, is_meta, metadata, new_index); else passed++;
      step();
    end
    total++; if (is_meta !== 1'b0 || metadata !== 8'h00)
      $display("FAIL meta_release: got isMeta=%b md=%h exp 0/00", is_meta, metadata); else passed++;
    issue(2'd3, 8'h00, 8'h04);
    total++; if (selector !== 8'h04) $display("FAIL q_selector: got %h exp 04", selector); else passed++;
    n = 0;
    while (!rsp_valid && n < 20) begin step(); n++; end
    total++; if (n !== 3) $display("FAIL q_latency: rsp_valid after %0d edges, exp 3", n); else passed++;
    total++; if (rsp_bool !== 1'b1 || rsp_value !== 8'h77 || selector !== 8'h00)
      $display("FAIL q_rsp: got b=%b val=%h sel=%h exp 1/77/00", rsp_bool, rsp_value, selector); else passed++;
    step();
    total++; if (rsp_valid !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1)
      $display("FAIL q_done: got rsp_valid=%b busy=%b ready=%b exp 0/0/1", rsp_valid, busy, cmd_ready); else passed++;
  endtask

  task automatic test_rsp_backpressure();
    int n;
    rsp_ready = 1'b0;
    issue(2'd3, 8'h00, 8'h04);
    n = 0;
    while (!rsp_valid && n < 20) begin step(); n++; end
    if (n >= 20) begin total++; $display("FAIL bp_timeout: rsp_valid=0 after 20 cycles, exp 1"); end
    for (int i = 0; i < 10; i++) begin
      total++; if (rsp_valid !== 1'b1 || rsp_bool !== 1'b1 || rsp_value !== 8'h77)
        $display("FAIL bp_hold[%0d]: got v=%b b=%b val=%h exp 1/1/77", i, rsp_valid, rsp_bool, rsp_value); else passed++;
      total++; if (cmd_ready !== 1'b0 || selector !== 8'h00 || busy !== 1'b1)
        $display("FAIL bp_ctrl[%0d]: got ready=%b sel=%h busy=%b exp 0/00/1", i, cmd_ready, selector, busy); else passed++;
      step();
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    total++; if (rsp_valid !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1 || rsp_value !== 8'h00)
      $display("FAIL bp_release: got v=%b busy=%b ready=%b val=%h exp 0/0/1/00", rsp_valid, busy, cmd_ready, rsp_value); else passed++;
  endtask

  task automatic test_back_to_back();
    logic [1:0] ops [3];
    logic [7:0] idxs[3];
    logic [7:0] vals[3];
    int exp_acc[3];
    int got_acc[3];
    int k;
    int rsp_cnt;
    logic will_accept;
    ops  = '{2'd1, 2'd3, 2'd0};
    idxs = '{8'h07, 8'h00, 8'h09};
    vals = '{8'h3C, 8'h04, 8'hEE};
`ifdef ESFA_CMD_SKID_EN
    exp_acc = '{0, 1, 5};
`else
    exp_acc = '{0, 4, 9};
`endif
    got_acc = '{-1, -1, -1};
    k = 0; rsp_cnt = 0;
    rsp_ready = 1'b1;
    cmd_op = ops[0]; cmd_index = idxs[0]; cmd_value = vals[0]; cmd_valid = 1'b1;
    for (int cyc = 0; cyc < 40; cyc++) begin
      will_accept = cmd_valid && cmd_ready;
`ifndef ESFA_CMD_SKID_EN
      if (will_accept) begin
        total++; if (busy !== 1'b0) $display("FAIL b2b_accept_busy: accept at cycle %0d with busy=%b exp 0", cyc, busy); else passed++;
      end
`endif
      step();
      if (rsp_valid) rsp_cnt++;
      if (will_accept) begin
        got_acc[k] = cyc;
        k++;
        if (k == 3) cmd_valid = 1'b0;
        else begin cmd_op = ops[k]; cmd_index = idxs[k]; cmd_value = vals[k]; end
      end
    end
    cmd_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      total++; if (got_acc[i] !== exp_acc[i])
        $display("FAIL b2b_accept[%0d]: got cycle %0d exp %0d", i, got_acc[i], exp_acc[i]); else passed++;
    end
    total++; if (rsp_cnt !== 1) $display("FAIL b2b_rsp_count: got %0d exp 1", rsp_cnt); else passed++;
    total++; if (new_index !== 8'hFF || new_value !== 8'h00 || selector !== 8'h00 || is_meta !== 1'b0 || busy !== 1'b0)
      $display("FAIL b2b_nop_quiet: got idx=%h val=%h sel=%h md=%b busy=%b exp ff/00/00/0/0",
               new_index, new_value, selector, is_meta, busy); else passed++;
  endtask

`ifdef ESFA_CMD_SKID_EN
  task automatic test_skid();
    int n;
    rsp_ready = 1'b1;
    cmd_op = 2'd1; cmd_index = 8'h01; cmd_value = 8'h22; cmd_valid = 1'b1;
    total++; if (cmd_ready !== 1'b1) $display("FAIL skid_ready0: got %b exp 1", cmd_ready); else passed++;
    step();
    total++; if (busy !== 1'b1 || new_index !== 8'h01 || cmd_ready !== 1'b1)
      $display("FAIL skid_wr: got busy=%b idx=%h ready=%b exp 1/01/1", busy, new_index, cmd_ready); else passed++;
    cmd_op = 2'd3; cmd_index = 8'h00; cmd_value = 8'h04;
    step();
    cmd_valid = 1'b0;
    total++; if (cmd_ready !== 1'b0 || selector !== 8'h00)
      $display("FAIL skid_held: got ready=%b sel=%h exp 0/00", cmd_ready, selector); else passed++;
    step();
    step();
    total++; if (busy !== 1'b0 || new_index !== 8'hFF || selector !== 8'h00)
      $display("FAIL skid_idle_cycle: got busy=%b idx=%h sel=%h exp 0/ff/00", busy, new_index, selector); else passed++;
    step();
    total++; if (selector !== 8'h04 || busy !== 1'b1 || cmd_ready !== 1'b1)
      $display("FAIL skid_dispatch: got sel=%h busy=%b ready=%b exp 04/1/1", selector, busy, cmd_ready); else passed++;
    n = 0;
    while (!rsp_valid && n < 20) begin step(); n++; end
    total++; if (rsp_value !== 8'h77 || n !== 3)
      $display("FAIL skid_rsp: got val=%h after %0d edges exp 77 after 3", rsp_value, n); else passed++;
    step();
  endtask
`endif

  initial begin
    test_reset();
    test_write();
    test_meta_query();
    test_rsp_backpressure();
    test_back_to_back();
`ifdef ESFA_CMD_SKID_EN
    test_skid();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
